// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
// Imported by the scoreboard and the arbitration top level.
package rf_sched_pkg;

  localparam int XLEN       = 32;
  localparam int REG_IDX_W  = 5;
  localparam int NUM_REGS   = 32;
  localparam int WAIT_CNT_W = 4;
  // Wide enough for the largest legal in-flight limit (7).
  localparam int OUTST_W    = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [NUM_REGS-1:0]  busy_vec_t;
  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;
  typedef logic [OUTST_W-1:0]   outst_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // Which requester owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_MDU
  } wr_src_e;

  function automatic wait_cnt_t sat_inc_wait(input wait_cnt_t v);
    return (v == '1) ? v : wait_cnt_t'(v + 1'b1);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy bits for in-flight MDU destinations plus the MDU in-flight counter.
// A set and a clear of the same register in one cycle leaves it busy.
module rf_scoreboard
  import rf_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      issue_en,
  input  logic      set_en,
  input  reg_idx_t  set_idx,
  input  logic      clr_en,
  input  reg_idx_t  clr_idx,
  output busy_vec_t busy,
  output outst_t    outstanding,
  output logic      full
);

  localparam outst_t MAX_OUT = outst_t'(MAX_OUTSTANDING);

  busy_vec_t busy_nxt;
  outst_t    out_nxt;

  assign full = (outstanding == MAX_OUT);

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[set_idx] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  // Issue and retire in the same cycle cancel out; underflow is held at zero.
  always_comb begin
    out_nxt = outstanding;
    case ({issue_en, clr_en})
      2'b10:   if (!full) out_nxt = outstanding + 1'b1;
      2'b01:   if (outstanding != '0) out_nxt = outstanding - 1'b1;
      default: out_nxt = outstanding;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= '0;
      outstanding <= '0;
    end else begin
      busy        <= busy_nxt;
      outstanding <= out_nxt;
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    clr_en |-> outstanding != '0)
    else $error("MDU response with no MDU op in flight");

  a_rsp_to_busy: assert property (@(posedge clk) disable iff (reset)
    (clr_en && clr_idx != REG_ZERO) |-> busy[clr_idx])
    else $error("MDU response to a register that is not busy");

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    issue_en |-> !full)
    else $error("MDU issue while in-flight limit reached");

endmodule

// File: rtl/rf_wb_scheduler.sv
// Shares the register-file write port between pipeline WB and the MDU, and
// stalls issue on RAW/WAW hazards against in-flight MDU destinations.
module rf_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int MAX_WAIT        = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rs1,
  input  logic [REG_IDX_W-1:0] issue_rs2,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 issue_uses_rd,
  input  logic                 issue_is_mdu,
  output logic                 issue_stall,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 wb_stall,
  input  logic                 mdu_rsp_valid,
  input  logic [REG_IDX_W-1:0] mdu_rsp_rd,
  input  logic [XLEN-1:0]      mdu_rsp_data,
  output logic                 mdu_rsp_ready,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_rd,
  output logic [XLEN-1:0]      rf_din,
  output logic [NUM_REGS-1:0]  busy_mask
);

  localparam wait_cnt_t WAIT_LIMIT = wait_cnt_t'(MAX_WAIT);

  wait_cnt_t wait_cnt;
  busy_vec_t busy;
  outst_t    outstanding;
  logic      sb_full;
  wr_src_e   wr_src;

  logic wb_eff, mdu_eff, grant_mdu, mdu_hs, issue_fire, hazard;

  // Writes to x0 never compete for the port.
  assign wb_eff    = wb_valid && (wb_rd != REG_ZERO);
  assign mdu_eff   = mdu_rsp_valid && (mdu_rsp_rd != REG_ZERO);
  assign grant_mdu = mdu_eff && (!wb_eff || wait_cnt >= WAIT_LIMIT);

  assign mdu_rsp_ready = !reset && (grant_mdu || (mdu_rsp_valid && mdu_rsp_rd == REG_ZERO));
  assign wb_stall      = !reset && wb_eff && grant_mdu;
  assign mdu_hs        = mdu_rsp_valid && mdu_rsp_ready;

  // Registered scoreboard only: a register freed at an edge becomes issuable the next cycle.
  assign hazard = busy[issue_rs1] || busy[issue_rs2] ||
                  (issue_uses_rd && busy[issue_rd]) ||
                  (issue_is_mdu && sb_full);
  assign issue_stall = !reset && issue_valid && hazard;
  assign issue_fire  = issue_valid && !issue_stall;
  assign busy_mask   = busy;

  always_comb begin
    wr_src = SRC_NONE;
    if (!reset) begin
      if (grant_mdu)   wr_src = SRC_MDU;
      else if (wb_eff) wr_src = SRC_WB;
    end
  end

  always_comb begin
    rf_we  = 1'b0;
    rf_rd  = REG_ZERO;
    rf_din = '0;
    case (wr_src)
      SRC_MDU: begin
        rf_we  = 1'b1;
        rf_rd  = mdu_rsp_rd;
        rf_din = mdu_rsp_data;
      end
      SRC_WB: begin
        rf_we  = 1'b1;
        rf_rd  = wb_rd;
        rf_din = wb_data;
      end
      default: rf_we = 1'b0;
    endcase
  end

  // Starvation counter: counts consecutive refused MDU cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     wait_cnt <= '0;
    else if (mdu_eff && !grant_mdu) wait_cnt <= sat_inc_wait(wait_cnt);
    else                           wait_cnt <= '0;
  end

  rf_scoreboard #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (issue_fire && issue_is_mdu),
    .set_en     (issue_fire && issue_is_mdu && issue_uses_rd && issue_rd != REG_ZERO),
    .set_idx    (issue_rd),
    .clr_en     (mdu_hs),
    .clr_idx    (mdu_rsp_rd),
    .busy       (busy),
    .outstanding(outstanding),
    .full       (sb_full)
  );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: WB path, RAW stall, starvation,
// in-flight limit, x0 handling and asynchronous reset.
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_uses_rd, issue_is_mdu, issue_stall;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        wb_valid, wb_stall;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_rsp_valid, mdu_rsp_ready;
  logic [4:0]  mdu_rsp_rd;
  logic [31:0] mdu_rsp_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_din;
  logic [31:0] busy_mask;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rf_model [32];
  // {rf_we, rf_rd, rf_din, wb_stall, mdu_rsp_ready}
  logic [39:0] port_obs;
  assign port_obs = {rf_we, rf_rd, rf_din, wb_stall, mdu_rsp_ready};

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) rf_model[rf_rd] <= rf_din;

  rf_wb_scheduler #(.MAX_WAIT(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_uses_rd(issue_uses_rd), .issue_is_mdu(issue_is_mdu),
    .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_rsp_valid(mdu_rsp_valid), .mdu_rsp_rd(mdu_rsp_rd), .mdu_rsp_data(mdu_rsp_data),
    .mdu_rsp_ready(mdu_rsp_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_din(rf_din), .busy_mask(busy_mask)
  );

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_uses_rd = 0; issue_is_mdu = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    mdu_rsp_valid = 0; mdu_rsp_rd = 0; mdu_rsp_data = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive_issue(input logic mdu, input logic [4:0] rd, input logic [4:0] rs1);
    issue_valid = 1; issue_is_mdu = mdu; issue_uses_rd = 1;
    issue_rd = rd; issue_rs1 = rs1; issue_rs2 = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle();
    drive_issue(1, 5'd3, 5'd0);
    wb_valid = 1; wb_rd = 5; wb_data = 32'h55;
    mdu_rsp_valid = 1; mdu_rsp_rd = 4; mdu_rsp_data = 32'h44;
    #3;
    n_cmp++;
    if (port_obs !== 40'h0) begin
      n_bad++; $display("FAIL reset_ports: got %h want %h", port_obs, 40'h0);
    end
    n_cmp++;
    if ({issue_stall, busy_mask} !== 33'h0) begin
      n_bad++; $display("FAIL reset_state: got %h want 0", {issue_stall, busy_mask});
    end
    @(posedge clk); #1;
    reset = 0;
    idle();
    cyc();
  endtask

  task automatic test_wb_write();
    wb_valid = 1; wb_rd = 5; wb_data = 32'h1234;
    #1;
    n_cmp++;
    if (port_obs !== {1'b1, 5'd5, 32'h1234, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL wb_write: got %h want %h", port_obs, {1'b1, 5'd5, 32'h1234, 2'b00});
    end
    cyc();
    n_cmp++;
    if (rf_model[5] !== 32'h1234) begin
      n_bad++; $display("FAIL wb_x5: got %h want 00001234", rf_model[5]);
    end
    wb_rd = 0; wb_data = 32'hFFFF;
    #1;
    n_cmp++;
    if (port_obs !== 40'h0) begin
      n_bad++; $display("FAIL wb_x0: got %h want 0", port_obs);
    end
    idle();
    cyc();
  endtask

  task automatic test_raw_stall();
    drive_issue(1, 5'd7, 5'd0);
    #1;
    n_cmp++;
    if (issue_stall !== 1'b0) begin
      n_bad++; $display("FAIL raw_mdu_issue: got %b want 0", issue_stall);
    end
    cyc();
    drive_issue(0, 5'd1, 5'd7);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if ({issue_stall, busy_mask} !== {1'b1, 32'h80}) begin
        n_bad++; $display("FAIL raw_stall%0d: got %h want 100000080", i, {issue_stall, busy_mask});
      end
      cyc();
    end
    mdu_rsp_valid = 1; mdu_rsp_rd = 7; mdu_rsp_data = 32'hCAFE;
    #1;
    n_cmp++;
    if ({port_obs, issue_stall} !== {1'b1, 5'd7, 32'hCAFE, 1'b0, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL raw_rsp: got %h want %h", {port_obs, issue_stall},
                        {1'b1, 5'd7, 32'hCAFE, 3'b011});
    end
    cyc();
    mdu_rsp_valid = 0;
    #1;
    n_cmp++;
    if ({issue_stall, busy_mask, rf_model[7]} !== {1'b0, 32'h0, 32'hCAFE}) begin
      n_bad++; $display("FAIL raw_release: got %h want %h", {issue_stall, busy_mask, rf_model[7]},
                        {1'b0, 32'h0, 32'hCAFE});
    end
    cyc();
    idle();
  endtask

  task automatic test_starvation();
    drive_issue(1, 5'd9, 5'd0);
    cyc();
    drive_issue(1, 5'd12, 5'd0);
    cyc();
    idle();
    wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
    mdu_rsp_valid = 1; mdu_rsp_rd = 9; mdu_rsp_data = 32'h99;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        #1;
        n_cmp++;
        if (port_obs !== {1'b1, 5'd3, 32'h33, 1'b0, 1'b0}) begin
          n_bad++; $display("FAIL starve_wait r%0d c%0d: got %h want %h", r, i, port_obs,
                            {1'b1, 5'd3, 32'h33, 2'b00});
        end
        cyc();
      end
      #1;
      n_cmp++;
      if (port_obs !== {1'b1, mdu_rsp_rd, mdu_rsp_data, 1'b1, 1'b1}) begin
        n_bad++; $display("FAIL starve_grant r%0d: got %h want rd %0d", r, port_obs, mdu_rsp_rd);
      end
      cyc();
      mdu_rsp_rd = 12; mdu_rsp_data = 32'hC12;
    end
    idle();
    #1;
    n_cmp++;
    if (busy_mask !== 32'h0) begin
      n_bad++; $display("FAIL starve_busy: got %h want 0", busy_mask);
    end
    cyc();
  endtask

  task automatic test_outstanding_limit();
    drive_issue(1, 5'd10, 5'd0);
    #1;
    n_cmp++;
    if (issue_stall !== 1'b0) begin
      n_bad++; $display("FAIL lim_first: got %b want 0", issue_stall);
    end
    cyc();
    drive_issue(1, 5'd11, 5'd0);
    cyc();
    drive_issue(1, 5'd13, 5'd0);
    #1;
    n_cmp++;
    if ({issue_stall, busy_mask} !== {1'b1, 32'hC00}) begin
      n_bad++; $display("FAIL lim_full: got %h want 100000c00", {issue_stall, busy_mask});
    end
    cyc();
    mdu_rsp_valid = 1; mdu_rsp_rd = 10; mdu_rsp_data = 32'hA0;
    #1;
    n_cmp++;
    if ({issue_stall, mdu_rsp_ready} !== 2'b11) begin
      n_bad++; $display("FAIL lim_same_cycle: got %b want 11", {issue_stall, mdu_rsp_ready});
    end
    cyc();
    mdu_rsp_valid = 0;
    #1;
    n_cmp++;
    if (issue_stall !== 1'b0) begin
      n_bad++; $display("FAIL lim_fire: got %b want 0", issue_stall);
    end
    cyc();
    drive_issue(1, 5'd14, 5'd0);
    #1;
    n_cmp++;
    if ({issue_stall, busy_mask} !== {1'b1, 32'h2800}) begin
      n_bad++; $display("FAIL lim_refull: got %h want 100002800", {issue_stall, busy_mask});
    end
    drive_issue(0, 5'd15, 5'd0);
    #1;
    n_cmp++;
    if (issue_stall !== 1'b0) begin
      n_bad++; $display("FAIL lim_alu_free: got %b want 0", issue_stall);
    end
    idle();
    mdu_rsp_valid = 1; mdu_rsp_rd = 11;
    cyc();
    mdu_rsp_rd = 13;
    cyc();
    idle();
    #1;
    n_cmp++;
    if (busy_mask !== 32'h0) begin
      n_bad++; $display("FAIL lim_drain: got %h want 0", busy_mask);
    end
    cyc();
  endtask

  task automatic test_x0_cases();
    drive_issue(1, 5'd4, 5'd0);
    cyc();
    drive_issue(1, 5'd0, 5'd0);
    issue_uses_rd = 0;
    cyc();
    idle();
    wb_valid = 1; wb_rd = 0; wb_data = 32'hDEAD;
    mdu_rsp_valid = 1; mdu_rsp_rd = 4; mdu_rsp_data = 32'h44;
    #1;
    n_cmp++;
    if (port_obs !== {1'b1, 5'd4, 32'h44, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL x0_wb: got %h want %h", port_obs, {1'b1, 5'd4, 32'h44, 2'b01});
    end
    cyc();
    wb_rd = 6; wb_data = 32'h66;
    mdu_rsp_rd = 0; mdu_rsp_data = 32'hBAD;
    #1;
    n_cmp++;
    if (port_obs !== {1'b1, 5'd6, 32'h66, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL x0_mdu: got %h want %h", port_obs, {1'b1, 5'd6, 32'h66, 2'b01});
    end
    cyc();
    idle();
    #1;
    n_cmp++;
    if ({busy_mask, rf_model[4]} !== {32'h0, 32'h44}) begin
      n_bad++; $display("FAIL x0_after: got %h want 0000000000000044", {busy_mask, rf_model[4]});
    end
    cyc();
  endtask

  task automatic test_async_reset();
    drive_issue(1, 5'd10, 5'd0);
    cyc();
    drive_issue(1, 5'd11, 5'd0);
    cyc();
    drive_issue(0, 5'd1, 5'd10);
    wb_valid = 1; wb_rd = 2; wb_data = 32'h22;
    #1;
    n_cmp++;
    if ({issue_stall, rf_we, busy_mask} !== {2'b11, 32'hC00}) begin
      n_bad++; $display("FAIL arst_before: got %h want 300000c00", {issue_stall, rf_we, busy_mask});
    end
    #1;
    reset = 1;
    #1;
    n_cmp++;
    if ({issue_stall, busy_mask, port_obs} !== 73'h0) begin
      n_bad++; $display("FAIL arst_now: got %h want 0", {issue_stall, busy_mask, port_obs});
    end
    @(posedge clk); #1;
    reset = 0;
    idle();
    cyc();
    drive_issue(1, 5'd20, 5'd0);
    cyc();
    drive_issue(1, 5'd21, 5'd0);
    #1;
    n_cmp++;
    if ({issue_stall, busy_mask} !== {1'b0, 32'h0010_0000}) begin
      n_bad++; $display("FAIL arst_after: got %h want 000100000", {issue_stall, busy_mask});
    end
    cyc();
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    test_reset();
    test_wb_write();
    test_raw_stall();
    test_starvation();
    test_outstanding_limit();
    test_x0_cases();
    test_async_reset();
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "timeout");
  end

endmodule
